crypt_sequencer: RTL

Hardware sequencer for the program-1 encryption datapath. After `req` releases, it reads the preamble length, tap pattern and seed from data memory. It then walks 64 padded character slots, XORs each biased character with a 7-bit maximal-length LFSR state, and writes the ciphertext to data memory bytes 64..127. It sits beside the data memory as a second master and raises `ack` when the run is complete.

---
 rtl/crypt_sequencer_pkg.sv | 37 +++
 rtl/crypt_sequencer_if.sv | 35 +++
 rtl/crypt_sequencer_lfsr7.sv | 27 ++
 rtl/crypt_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/crypt_sequencer_pkg.sv
// Shared types and constants for the program-1 encryption sequencer.
// Contents: FSM state enum, memory-map constants, slot/pre-length limits,
// and the 7-bit LFSR next-state helper used by the lfsr7 sub-module.
package crypt_pkg;

   localparam int unsigned ADDR_PRE  = 61;
   localparam int unsigned ADDR_TAP  = 62;
   localparam int unsigned ADDR_SEED = 63;
   localparam int unsigned OUT_BASE  = 64;
   localparam int unsigned NUM_SLOTS = 64;
   localparam int unsigned PRE_MIN   = 10;
   localparam int unsigned PRE_MAX   = 26;

   localparam int unsigned LFSR_W = 7;
   localparam int unsigned SLOT_W = 6;
   localparam int unsigned PRE_W  = 5;

   typedef enum logic [3:0] {
      IDLE,
      PRE_A,
      PRE_C,
      TAP_A,
      TAP_C,
      SEED_A,
      SEED_C,
      FETCH,
      WRITE,
      DONE
   } crypt_state_t;

   // Shift left, feed back the parity of the tapped bits.
   function automatic logic [LFSR_W-1:0] lfsr7_next(input logic [LFSR_W-1:0] state,
                                                    input logic [LFSR_W-1:0] tap);
      return {state[LFSR_W-2:0], ^(state & tap)};
   endfunction

endpackage

// File: rtl/crypt_sequencer_if.sv
// Handshake and data-memory master bus of the encryption sequencer.
// Signals: req (start/abort), ack (run complete), mem_addr, mem_wr,
// mem_wdata, mem_rdata (valid the cycle after mem_addr).
// master: the sequencer side; slave: the requester/memory side.
interface crypt_sequencer_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
) ();

   logic          req;
   logic          ack;
   logic [AW-1:0] mem_addr;
   logic          mem_wr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport master (
      input  req,
      input  mem_rdata,
      output ack,
      output mem_addr,
      output mem_wr,
      output mem_wdata
   );

   modport slave (
      output req,
      output mem_rdata,
      input  ack,
      input  mem_addr,
      input  mem_wr,
      input  mem_wdata
   );

endinterface

// File: rtl/crypt_sequencer_lfsr7.sv
// 7-bit Fibonacci-style LFSR with loadable seed and tap pattern.
// Ports: clk, init_n (async active-low, resets q to 0x01), load (q <= seed),
// seed[6:0], tap[6:0], step (advance one state), q[6:0].
module lfsr7
   import crypt_pkg::*;
(
   input  logic              clk,
   input  logic              init_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic [LFSR_W-1:0] tap,
   input  logic              step,
   output logic [LFSR_W-1:0] q
);

   // load has priority over step
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         q <= LFSR_W'(1);
      end else if (load) begin
         q <= seed;
      end else if (step) begin
         q <= lfsr7_next(q, tap);
      end
   end

endmodule

// File: rtl/crypt_sequencer.sv
// Program-1 encryption sequencer: second master on the data memory.
// Reads pre_len/tap/seed from 61..63, then encrypts 64 padded character
// slots (leading pre_len slots are biased spaces, the rest come from the
// message at 0..) by XOR with a 7-bit LFSR, writing bytes 64..127.
// Ports: clk, init_n (async active-low), bus (crypt_sequencer_if.master).
// Build option: define CRYPT_PARITY_EN to put even parity of the 7 cipher
// bits in mem_wdata[7]; otherwise bit 7 is 0.
module crypt_sequencer
   import crypt_pkg::*;
#(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
) (
   input logic               clk,
   input logic               init_n,
   crypt_sequencer_if.master bus
);

   crypt_state_t      state;
   logic [SLOT_W-1:0] slot;
   logic [PRE_W-1:0]  pre_len;
   logic [LFSR_W-1:0] tap;
   logic              armed;
   logic              ack_q;
   logic              wr_q;
   logic [AW-1:0]     addr_q;

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] seed_c;
   logic              lfsr_load_c;
   logic              lfsr_step_c;
   logic [LFSR_W-1:0] char_c;
   logic [LFSR_W-1:0] cipher_c;
   logic              parity_c;

   // Clamp the stored preamble length into [PRE_MIN, PRE_MAX]
   function automatic logic [PRE_W-1:0] clamp_pre(input logic [DW-1:0] d);
      if (d < DW'(PRE_MIN)) return PRE_W'(PRE_MIN);
      if (d > DW'(PRE_MAX)) return PRE_W'(PRE_MAX);
      return PRE_W'(d);
   endfunction

   // Message address for a slot; preamble slots issue no read (address 0)
   function automatic logic [AW-1:0] fetch_addr(input logic [SLOT_W-1:0] s,
                                                input logic [PRE_W-1:0]  p);
      if (s >= SLOT_W'(p)) return AW'(s - SLOT_W'(p));
      return '0;
   endfunction

   lfsr7 u_lfsr (
      .clk    (clk),
      .init_n (init_n),
      .load   (lfsr_load_c),
      .seed   (seed_c),
      .tap    (tap),
      .step   (lfsr_step_c),
      .q      (lfsr_q)
   );

   // Seed load, LFSR advance and cipher byte for the current slot
   always_comb begin
      lfsr_load_c = (state == SEED_C);
      lfsr_step_c = (state == WRITE);
      seed_c      = bus.mem_rdata[LFSR_W-1:0];
      if (seed_c == '0) seed_c = LFSR_W'(1);
      char_c = '0;
      if ((state == WRITE) && (slot >= SLOT_W'(pre_len))) char_c = bus.mem_rdata[LFSR_W-1:0];
      cipher_c = char_c ^ lfsr_q;
`ifdef CRYPT_PARITY_EN
      parity_c = ^cipher_c;
`else
      parity_c = 1'b0;
`endif
   end

   // Sequencer FSM; req high outside IDLE aborts on the next edge
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state   <= IDLE;
         slot    <= '0;
         pre_len <= PRE_W'(PRE_MIN);
         tap     <= '0;
         armed   <= 1'b0;
         ack_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
      end else begin
         wr_q <= 1'b0;
         if (bus.req) armed <= 1'b1;
         if (bus.req && (state != IDLE)) begin
            state  <= IDLE;
            ack_q  <= 1'b0;
            addr_q <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (armed && !bus.req) begin
                     state  <= PRE_A;
                     armed  <= 1'b0;
                     slot   <= '0;
                     addr_q <= AW'(ADDR_PRE);
                  end
               end
               PRE_A: state <= PRE_C;
               PRE_C: begin
                  pre_len <= clamp_pre(bus.mem_rdata);
                  addr_q  <= AW'(ADDR_TAP);
                  state   <= TAP_A;
               end
               TAP_A: state <= TAP_C;
               TAP_C: begin
                  tap    <= bus.mem_rdata[LFSR_W-1:0];
                  addr_q <= AW'(ADDR_SEED);
                  state  <= SEED_A;
               end
               SEED_A: state <= SEED_C;
               SEED_C: begin
                  slot   <= '0;
                  addr_q <= fetch_addr('0, pre_len);
                  state  <= FETCH;
               end
               FETCH: begin
                  addr_q <= AW'(OUT_BASE) + AW'(slot);
                  wr_q   <= 1'b1;
                  state  <= WRITE;
               end
               WRITE: begin
                  if (slot == SLOT_W'(NUM_SLOTS - 1)) begin
                     addr_q <= '0;
                     state  <= DONE;
                  end else begin
                     slot   <= slot + SLOT_W'(1);
                     addr_q <= fetch_addr(slot + SLOT_W'(1), pre_len);
                     state  <= FETCH;
                  end
               end
               DONE: ack_q <= 1'b1;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.ack      = ack_q;
   assign bus.mem_wr   = wr_q;
   assign bus.mem_addr = addr_q;
   // Read data for the slot only arrives during WRITE, so the byte is formed
   // from registered state plus mem_rdata and forced to 0 outside WRITE.
   assign bus.mem_wdata = (state == WRITE) ? DW'({parity_c, cipher_c}) : '0;

endmodule
